// File: rtl/serial_cmp_lu_pkg.sv
// rtl/serial_cmp_lu_pkg.sv - shared mode codes, FSM states and result mapping for serial_cmp_lu
package lu_pkg;

    // Compare modes; 3'b110 and 3'b111 are reserved
    typedef enum logic [2:0] {
        LU_LT  = 3'b000,
        LU_GT  = 3'b001,
        LU_EQ  = 3'b010,
        LU_NE  = 3'b011,
        LU_LE  = 3'b100,
        LU_GE  = 3'b101,
        LU_RSV = 3'b110
    } lu_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } lu_state_e;

    function automatic logic mode_is_reserved(input logic [2:0] mode);
        return (mode[2:1] == 2'b11);
    endfunction

    // Boolean outcome of a finished compare; reserved modes always give 0
    function automatic logic mode_to_result(input logic [2:0] mode, input logic gt,
                                            input logic lt, input logic eq);
        logic r;
        case (mode)
            LU_LT:   r = lt;
            LU_GT:   r = gt;
            LU_EQ:   r = eq;
            LU_NE:   r = ~eq;
            LU_LE:   r = lt | eq;
            LU_GE:   r = gt | eq;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/serial_cmp_lu_if.sv
// rtl/serial_cmp_lu_if.sv - start/ready/done request and result bundle for serial_cmp_lu
interface serial_cmp_lu_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       mode;
    logic             ready;
    logic             done;
    logic             result;
    logic             gt;
    logic             lt;
    logic             eq;
    logic             bad_mode;

    modport master (
        output start, a, b, mode,
        input  ready, done, result, gt, lt, eq, bad_mode
    );

    modport slave (
        input  start, a, b, mode,
        output ready, done, result, gt, lt, eq, bad_mode
    );
endinterface

// File: rtl/serial_cmp_lu_cell.sv
// rtl/serial_cmp_lu_cell.sv - one-bit greater/less cell with role swap for a signed MSB
module bit_cmp_cell (
    input  logic a_i,
    input  logic b_i,
    input  logic inv_i,
    output logic gt_o,
    output logic lt_o
);
    logic a_over_b;
    logic b_over_a;

    // A 1 against a 0 means "larger" except at a two's complement sign bit
    assign a_over_b = a_i & ~b_i;
    assign b_over_a = ~a_i & b_i;
    assign gt_o     = inv_i ? b_over_a : a_over_b;
    assign lt_o     = inv_i ? a_over_b : b_over_a;
endmodule

// File: rtl/serial_cmp_lu.sv
// rtl/serial_cmp_lu.sv - bit-serial MSB-first magnitude compare unit; SERIAL_CMP_EARLY_EXIT_EN ends RUN at the first differing bit
module serial_cmp_lu #(
    parameter int WIDTH  = 8,
    parameter bit SIGNED = 1'b0
) (
    input  logic            clk,
    input  logic            reset,
    serial_cmp_lu_if.slave  bus
);
    import lu_pkg::*;

    localparam int              IDX_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(WIDTH - 1);

    lu_state_e        state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [2:0]       mode_q;
    logic [IDX_W-1:0] idx_q;
    logic             gt_s_q;
    logic             lt_s_q;
    logic             ready_q;
    logic             done_q;
    logic             result_q;
    logic             gt_q;
    logic             lt_q;
    logic             eq_q;
    logic             bad_q;

    logic cell_gt;
    logic cell_lt;
    logic found;
    logic gt_d;
    logic lt_d;
    logic eq_d;
    logic decided;

    bit_cmp_cell u_cell (
        .a_i   (a_q[idx_q]),
        .b_i   (b_q[idx_q]),
        .inv_i (SIGNED && (idx_q == IDX_MSB)),
        .gt_o  (cell_gt),
        .lt_o  (cell_lt)
    );

    // Once a differing bit has set a scratch flag, lower bits can no longer change it
    assign found = gt_s_q | lt_s_q;
    assign gt_d  = gt_s_q | (~found & cell_gt);
    assign lt_d  = lt_s_q | (~found & cell_lt);
    assign eq_d  = ~(gt_d | lt_d);

`ifdef SERIAL_CMP_EARLY_EXIT_EN
    assign decided = (idx_q == '0) || gt_d || lt_d;
`else
    assign decided = (idx_q == '0);
`endif

    // Control FSM with operand capture, serial scan and registered result outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            mode_q   <= '0;
            idx_q    <= '0;
            gt_s_q   <= 1'b0;
            lt_s_q   <= 1'b0;
            ready_q  <= 1'b1;
            done_q   <= 1'b0;
            result_q <= 1'b0;
            gt_q     <= 1'b0;
            lt_q     <= 1'b0;
            eq_q     <= 1'b0;
            bad_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (bus.start) begin
                        a_q     <= bus.a;
                        b_q     <= bus.b;
                        mode_q  <= bus.mode;
                        idx_q   <= IDX_MSB;
                        gt_s_q  <= 1'b0;
                        lt_s_q  <= 1'b0;
                        ready_q <= 1'b0;
                        state_q <= ST_RUN;
                    end else begin
                        ready_q <= 1'b1;
                        state_q <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    gt_s_q <= gt_d;
                    lt_s_q <= lt_d;
                    if (decided) begin
                        gt_q     <= gt_d;
                        lt_q     <= lt_d;
                        eq_q     <= eq_d;
                        result_q <= mode_to_result(mode_q, gt_d, lt_d, eq_d);
                        bad_q    <= mode_is_reserved(mode_q);
                        done_q   <= 1'b1;
                        ready_q  <= 1'b1;
                        state_q  <= ST_DONE;
                    end else if (idx_q != '0) begin
                        idx_q <= idx_q - 1'b1;
                    end
                end
                default: begin
                    ready_q <= 1'b1;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.ready    = ready_q;
    assign bus.done     = done_q;
    assign bus.result   = result_q;
    assign bus.gt       = gt_q;
    assign bus.lt       = lt_q;
    assign bus.eq       = eq_q;
    assign bus.bad_mode = bad_q;

endmodule
